// File: rtl/mem_access.sv
// MEM stage: passes ALU results through and runs loads/stores as byte-serial
// accesses on the shared memctrl bus, stalling the pipeline until the access completes.
module mem_access #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [5:0]        stall,
  input  logic [4:0]        mac_wd,
  input  logic              mac_wreg,
  input  logic [31:0]       mac_wdata,
  input  logic [7:0]        mac_aluop,
  input  logic [31:0]       mac_mem_addr,
  input  logic [31:0]       mac_reg2,
  input  logic [31:0]       mac_pc,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [7:0]        mc_wdata,
  input  logic              mc_gnt,
  input  logic [7:0]        mc_rdata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic              stallreq_mem
);

  localparam logic [7:0] ExeLbOp  = 8'hE0;
  localparam logic [7:0] ExeLhOp  = 8'hE1;
  localparam logic [7:0] ExeLwOp  = 8'hE3;
  localparam logic [7:0] ExeLbuOp = 8'hE4;
  localparam logic [7:0] ExeLhuOp = 8'hE5;
  localparam logic [7:0] ExeSbOp  = 8'hE8;
  localparam logic [7:0] ExeShOp  = 8'hE9;
  localparam logic [7:0] ExeSwOp  = 8'hEB;

  localparam logic [4:0] NopRegAddr = 5'd0;
  localparam logic       NoStop     = 1'b0;
  localparam logic [1:0] LatCnt     = 2'(READ_LAT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load, is_store, is_mem;
  logic [2:0]  nbytes;
  logic [31:0] load_ext;
  logic [4:0]  lane_sh;
  logic [31:0] wdata_sh, rdata_sh;

  logic              req_c, we_c, stall_c;
  logic [ADDR_W-1:0] addr_c;
  logic [7:0]        wbyte_c;

  logic unused_bits;
  assign unused_bits = ^{mac_pc, stall[5], stall[3:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    nbytes   = 3'd0;
    case (mac_aluop)
      ExeLbOp, ExeLbuOp: begin is_load  = 1'b1; nbytes = 3'd1; end
      ExeLhOp, ExeLhuOp: begin is_load  = 1'b1; nbytes = 3'd2; end
      ExeLwOp:           begin is_load  = 1'b1; nbytes = 3'd4; end
      ExeSbOp:           begin is_store = 1'b1; nbytes = 3'd1; end
      ExeShOp:           begin is_store = 1'b1; nbytes = 3'd2; end
      ExeSwOp:           begin is_store = 1'b1; nbytes = 3'd4; end
      default: ;
    endcase
  end
  assign is_mem = is_load | is_store;

  always_comb begin
    case (mac_aluop)
      ExeLbOp:  load_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      ExeLbuOp: load_ext = {24'd0, buf_q[7:0]};
      ExeLhOp:  load_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      ExeLhuOp: load_ext = {16'd0, buf_q[15:0]};
      default:  load_ext = buf_q;
    endcase
  end

  // Little-endian: byte cnt lives in bits [8*cnt +: 8] of both store data and buffer.
  assign lane_sh  = {cnt_q[1:0], 3'b000};
  assign wdata_sh = mac_reg2 >> lane_sh;
  assign rdata_sh = {24'd0, mc_rdata} << lane_sh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    buf_d   = buf_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wbyte_c = 8'd0;
    stall_c = 1'b0;
    case (state_q)
      StIdle, StReq: begin
        // A fresh memory op presents its first byte in the same cycle it is seen.
        if (state_q == StReq || is_mem) begin
          req_c   = 1'b1;
          we_c    = is_store;
          addr_c  = mac_mem_addr[ADDR_W-1:0] + ADDR_W'(cnt_q);
          wbyte_c = wdata_sh[7:0];
          stall_c = 1'b1;
          state_d = StReq;
          if (mc_gnt) begin
            if (is_store) begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_q + 3'd1 >= nbytes) state_d = StDone;
            end else begin
              state_d = StWait;
              wcnt_d  = 2'd1;
            end
          end
        end
      end
      StWait: begin
        stall_c = 1'b1;
        if (wcnt_q == LatCnt) begin
          buf_d   = buf_q | rdata_sh;
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q + 3'd1 < nbytes) ? StReq : StDone;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      StDone: begin
        if (stall[4] == NoStop) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      wcnt_q  <= 2'd0;
      buf_q   <= 32'd0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    mc_req       = req_c & rdy;
    mc_we        = we_c;
    mc_addr      = addr_c;
    mc_wdata     = wbyte_c;
    stallreq_mem = stall_c;
    mem_wd       = mac_wd;
    mem_wreg     = mac_wreg;
    mem_wdata    = mac_wdata;
    if (stall_c) begin
      mem_wd    = NopRegAddr;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
    end else if (state_q == StDone) begin
      mem_wreg  = mac_wreg & is_load;
      mem_wdata = is_load ? load_ext : 32'd0;
    end
    // Reset wins over any op still sitting on the mac_* inputs.
    if (rst) begin
      mc_req       = 1'b0;
      mc_we        = 1'b0;
      mc_addr      = '0;
      mc_wdata     = 8'd0;
      stallreq_mem = 1'b0;
      mem_wd       = NopRegAddr;
      mem_wreg     = 1'b0;
      mem_wdata    = 32'd0;
    end
  end

endmodule
